pwm_dac_out: RTL and testbench
==============================

PWM_DAC_OUT -- requirements
Module: pwm_dac_out

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning the PWM counter and duty width; this width is fixed to the 8-bit waveform sample width.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port en, input, 1, the run enable.
REQ-005 SHALL have port wave, input, 8, the unsigned sample from the upstream waveform/frequency stage.
REQ-006 SHALL have port wave_valid, input, 1, a one-cycle strobe marking a new wave sample.
REQ-007 SHALL have port amp, input, 2, the attenuation select: 0 = x1, 1 = x1/2, 2 = x1/4, 3 = x1/8.
REQ-008 SHALL have port pwm_out, output, 1, the registered PWM bit.
REQ-009 SHALL have port period_start, output, 1, a one-cycle pulse in the first cycle of each PWM period.
REQ-010 SHALL have port duty, output, 8, the currently active duty value.
REQ-011 SHALL have port stale, output, 1, asserted when the period that just loaded saw no wave_valid.

Function
REQ-012 SHALL hold an 8-bit counter cnt that increments by 1 per clk while en=1, wrapping 255 -> 0, so one period is 256 cycles.
REQ-013 SHALL hold cnt, duty, the sample register and the stale flag while en=0, and SHALL force pwm_out=0 and period_start=0 while en=0.
REQ-014 SHALL capture wave into a sample register on every clk with wave_valid=1; when several strobes occur in one period, the last one wins.
REQ-015 SHALL set a per-period seen flag on wave_valid, which is cleared at each load.
REQ-016 SHALL, in the cycle where cnt==255 and en=1, load duty <= (S >> amp) + (128 - (128 >> amp)) and latch amp into the active attenuation. S is the sample register, or wave itself if wave_valid is also 1 in that cycle.
REQ-017 SHALL compute the REQ-016 result in 8 bits without overflow (maximum 255 at amp=0); midscale 128 SHALL map to 128 for every amp value.
REQ-018 SHALL ignore amp and sample changes made mid-period until the next load, so duty changes only at period boundaries (glitch-free).
REQ-019 SHALL update stale together with each load: 1 if seen was 0 and wave_valid=0 in the load cycle, otherwise 0.
REQ-020 SHALL drive pwm_out <= (next cnt < duty) as a register, so pwm_out is high for exactly duty cycles of each 256-cycle period, starting at cnt==0. duty=0 gives always low; duty=255 gives low for 1 cycle per period.
REQ-021 SHALL assert period_start in the cycle where cnt==0 and en=1, including the first period after reset.
REQ-022 SHALL have a latency of one period boundary from sample to output: a sample strobed during period N sets duty for period N+1.

Reset
REQ-023 SHALL, when rst=1 at a clk edge, set cnt=255, duty=128, sample=128, active amp=0, seen=0, stale=0, pwm_out=0 and period_start=0.
REQ-024 SHALL have rst take priority over en and wave_valid.
REQ-025 SHALL, when rst is applied mid-period, abandon the current period; the first cycle with en=1 after reset SHALL be a load cycle (cnt==255), so the next period starts cleanly.

Structure
REQ-026 SHALL place CNT_W, the midscale constant 128 and the amp encoding constants in the shared function-generator package.
REQ-027 SHALL implement the shift-and-offset computation of REQ-016 as one combinational sub-module, amp_scale (inputs sample and amp, output scaled level); counter, registers and comparator stay in pwm_dac_out.

Verification
REQ-028 SHALL cover: reset, then en=1 and wave=200 strobed once per period at amp=0 -> from period 2 onward duty=200, pwm_out high for 200 of 256 cycles, stale=0.
REQ-029 SHALL cover: wave=200 at amp=1 -> duty=164; at amp=3 -> duty=137; wave=0 at amp=2 -> duty=96; wave=128 at any amp -> duty=128.
REQ-030 SHALL cover: amp switched 0 -> 2 at cnt=100 -> the current period keeps its duty, and the new duty appears only after the next cnt==255.
REQ-031 SHALL cover: no wave_valid for a full period -> stale=1 and duty repeats the previous value; one strobe in the next period -> stale returns to 0.
REQ-032 SHALL cover: en dropped at cnt=50 for 30 cycles -> pwm_out=0 throughout and cnt resumes at 50; rst asserted at cnt=77 -> all outputs take their REQ-023 values and period_start pulses on the second en cycle after reset.
REQ-033 SHALL cover: duty=0 and duty=255 -> pwm_out is constant 0, and low for exactly one cycle per period, respectively.

Source files
------------

// File: rtl/pwm_dac_out_pkg.sv
// Shared constants for the function-generator output stage: sample width,
// midscale level and the attenuation encoding.
package pwm_dac_out_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] MID_SCALE = 8'd128;

  typedef enum logic [1:0] {
    AMP_X1   = 2'd0,
    AMP_X1_2 = 2'd1,
    AMP_X1_4 = 2'd2,
    AMP_X1_8 = 2'd3
  } amp_e;

  // Offset that re-centres an attenuated sample so midscale stays at midscale.
  function automatic logic [CNT_W-1:0] mid_offset(input logic [1:0] amp);
    return MID_SCALE - (MID_SCALE >> amp);
  endfunction

endpackage

// File: rtl/pwm_dac_out_amp_scale.sv
// Combinational attenuator: shrinks a sample toward midscale by 2^amp.
// The sum tops out at 255 for amp=0, so it never overflows 8 bits.
module amp_scale
  import pwm_dac_out_pkg::*;
(
  input  logic [CNT_W-1:0] sample,
  input  logic [1:0]       amp,
  output logic [CNT_W-1:0] level
);

  assign level = (sample >> amp) + mid_offset(amp);

endmodule

// File: rtl/pwm_dac_out.sv
// 256-cycle PWM DAC. A new duty is computed from the latest sample and amp
// only at the period boundary, so the waveform never glitches mid-period.
module pwm_dac_out
  import pwm_dac_out_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] wave,
  input  logic             wave_valid,
  input  logic [1:0]       amp,
  output logic             pwm_out,
  output logic             period_start,
  output logic [CNT_W-1:0] duty,
  output logic             stale
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] sample;
  logic [CNT_W-1:0] act_sample;
  logic [CNT_W-1:0] load_sample;
  logic [CNT_W-1:0] load_level;
  logic [CNT_W-1:0] duty_next;
  amp_e             act_amp;
  logic             seen;
  logic             pwm_q;
  logic             load;

  assign load        = en && (cnt == '1);
  assign cnt_next    = cnt + 1'b1;
  assign load_sample = wave_valid ? wave : sample;

  amp_scale u_load_scale (
    .sample (load_sample),
    .amp    (amp),
    .level  (load_level)
  );

  // The active duty is derived from the pair latched at the last load.
  amp_scale u_active_scale (
    .sample (act_sample),
    .amp    (act_amp),
    .level  (duty)
  );

  // The compare for cnt==0 happens in the load cycle, so it must see the new duty.
  assign duty_next = load ? load_level : duty;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '1;
      sample     <= MID_SCALE;
      act_sample <= MID_SCALE;
      act_amp    <= AMP_X1;
      seen       <= 1'b0;
      stale      <= 1'b0;
      pwm_q      <= 1'b0;
    end else if (en) begin
      cnt   <= cnt_next;
      pwm_q <= (cnt_next < duty_next);
      if (wave_valid) begin
        sample <= wave;
      end
      if (load) begin
        act_sample <= load_sample;
        act_amp    <= amp_e'(amp);
        seen       <= 1'b0;
        stale      <= !seen && !wave_valid;
      end else if (wave_valid) begin
        seen <= 1'b1;
      end
    end
  end

  // pwm_q holds while paused so the waveform resumes exactly where it stopped.
  assign pwm_out      = pwm_q && en;
  assign period_start = en && (cnt == '0);

endmodule

// File: tb/tb_pwm_dac_out.sv
// Scoreboard bench for pwm_dac_out: each stimulated period pushes the duty/stale
// expected for the following period; a monitor pops them at every period_start.
module tb_pwm_dac_out;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] wave;
  logic       wave_valid;
  logic [1:0] amp;
  logic       pwm_out;
  logic       period_start;
  logic [7:0] duty;
  logic       stale;

  int         checks_total  = 0;
  int         checks_passed = 0;
  logic [8:0] exp_q[$];
  int         hi_count      = 0;
  logic [7:0] prev_duty     = 8'd0;
  bit         have_prev     = 1'b0;

  pwm_dac_out #(.CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .wave         (wave),
    .wave_valid   (wave_valid),
    .amp          (amp),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .duty         (duty),
    .stale        (stale)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    checks_total++;
    if (actual == expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full period starting at cnt==0; a single strobe lands at cnt==10.
  task automatic apply_stimulus(input logic [7:0] w, input bit strobe, input logic [1:0] a0,
                                input int switch_at, input logic [1:0] a1,
                                input logic [7:0] exp_duty, input bit exp_stale);
    exp_q.push_back({exp_stale, exp_duty});
    for (int c = 0; c < 256; c++) begin
      amp        = (switch_at >= 0 && c >= switch_at) ? a1 : a0;
      wave       = w;
      wave_valid = strobe && (c == 10);
      tick();
    end
    wave_valid = 1'b0;
  endtask

  // Monitor: compares duty/stale at each period start, the high-cycle count of
  // the period just finished, and that duty never moves mid-period.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      have_prev = 1'b0;
      hi_count  = 0;
    end else if (en) begin
      if (period_start) begin
        if (have_prev) check_output("pwm_high_count", hi_count, int'(prev_duty));
        if (exp_q.size() == 0) begin
          checks_total++;
          $display("[TB] FAIL unexpected_period: got period_start, expected none at time %0t", $time);
          have_prev = 1'b0;
        end else begin
          e = exp_q.pop_front();
          check_output("period_duty", int'(duty), int'(e[7:0]));
          check_output("period_stale", int'(stale), int'(e[8]));
          prev_duty = e[7:0];
          have_prev = 1'b1;
        end
        hi_count = int'(pwm_out);
      end else begin
        hi_count += int'(pwm_out);
        if (have_prev) check_output("duty_stable", int'(duty), int'(prev_duty));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst        = 1'b1;
    en         = 1'b0;
    wave       = 8'd0;
    wave_valid = 1'b0;
    amp        = 2'd0;
    repeat (2) tick();
    rst = 1'b0;
    check_output("reset_duty", int'(duty), 128);
    check_output("reset_stale", int'(stale), 0);
    check_output("reset_pwm", int'(pwm_out), 0);
    check_output("reset_period_start", int'(period_start), 0);

    // First en cycle is a load with no strobe ever seen, so period 0 is stale.
    exp_q.push_back({1'b1, 8'd128});
    en = 1'b1;
    tick();

    apply_stimulus(8'd200, 1'b1, 2'd0, -1, 2'd0, 8'd200, 1'b0);
    apply_stimulus(8'd200, 1'b1, 2'd1, -1, 2'd1, 8'd164, 1'b0);
    apply_stimulus(8'd200, 1'b1, 2'd3, -1, 2'd3, 8'd137, 1'b0);
    apply_stimulus(8'd0,   1'b1, 2'd2, -1, 2'd2, 8'd96,  1'b0);
    apply_stimulus(8'd128, 1'b1, 2'd1, -1, 2'd1, 8'd128, 1'b0);
    apply_stimulus(8'd128, 1'b1, 2'd3, -1, 2'd3, 8'd128, 1'b0);
    apply_stimulus(8'd128, 1'b1, 2'd2, -1, 2'd2, 8'd128, 1'b0);
    apply_stimulus(8'd200, 1'b1, 2'd0, -1, 2'd0, 8'd200, 1'b0);
    // amp 0 -> 2 at cnt 100: this period stays 200, next is 200/4 + 96.
    apply_stimulus(8'd200, 1'b1, 2'd0, 100, 2'd2, 8'd146, 1'b0);
    apply_stimulus(8'd200, 1'b0, 2'd2, -1, 2'd2, 8'd146, 1'b1);
    apply_stimulus(8'd0,   1'b1, 2'd0, -1, 2'd0, 8'd0,   1'b0);
    apply_stimulus(8'd255, 1'b1, 2'd0, -1, 2'd0, 8'd255, 1'b0);
    apply_stimulus(8'd200, 1'b1, 2'd0, -1, 2'd0, 8'd200, 1'b0);

    // Pause at cnt 50 during a duty-200 period.
    exp_q.push_back({1'b0, 8'd90});
    for (int c = 0; c < 50; c++) begin
      amp        = 2'd0;
      wave       = 8'd90;
      wave_valid = (c == 10);
      tick();
    end
    wave_valid = 1'b0;
    check_output("pwm_before_pause", int'(pwm_out), 1);
    en = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      check_output("pwm_paused", int'(pwm_out), 0);
      check_output("period_start_paused", int'(period_start), 0);
    end
    en = 1'b1;
    n  = 0;
    while (!period_start && n < 300) begin
      tick();
      n++;
    end
    check_output("cycles_to_period_after_resume", n, 206);

    // Reset at cnt 77 with en still high.
    for (int c = 0; c < 77; c++) begin
      amp        = 2'd0;
      wave       = 8'd30;
      wave_valid = (c == 10);
      tick();
    end
    wave_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en  = 1'b0;
    exp_q.delete();
    check_output("midreset_duty", int'(duty), 128);
    check_output("midreset_stale", int'(stale), 0);
    check_output("midreset_pwm", int'(pwm_out), 0);
    check_output("midreset_period_start", int'(period_start), 0);

    exp_q.push_back({1'b1, 8'd128});
    en = 1'b1;
    #1;
    check_output("ps_first_en_cycle", int'(period_start), 0);
    check_output("pwm_first_en_cycle", int'(pwm_out), 0);
    tick();
    check_output("ps_second_en_cycle", int'(period_start), 1);

    apply_stimulus(8'd100, 1'b1, 2'd1, -1, 2'd1, 8'd114, 1'b0);
    apply_stimulus(8'd0,   1'b0, 2'd0, -1, 2'd0, 8'd100, 1'b1);
    repeat (3) tick();
    check_output("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
